// File: rtl/switch_pkg.sv
// rtl/switch_pkg.sv - shared constants, FSM state type and width helper for the switch egress port
package switch_pkg;

    localparam logic [7:0] BROADCAST_ADDR = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        ACCEPT,
        DISCARD
    } state_t;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock byte FIFO with registered read data and occupancy count
module sync_fifo
    import switch_pkg::*;
#(
    parameter int W_WIDTH    = 8,
    parameter int FIFO_DEPTH = 16,
    localparam int PW        = ptr_width(FIFO_DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_push,
    input  logic [W_WIDTH-1:0] i_wdata,
    input  logic               i_pop,
    output logic [W_WIDTH-1:0] o_rdata,
    output logic               o_full,
    output logic               o_empty,
    output logic [PW:0]        o_count
);

    logic [W_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_rd_ptr;
    logic [PW:0]        r_count;
    logic [W_WIDTH-1:0] r_rdata;
    logic               w_push;
    logic               w_pop;

    assign o_full  = (r_count == (PW+1)'(FIFO_DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_rdata;
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Read data is held between pops, so the consumer sees a stable byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_rdata  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
                r_rdata  <= r_mem[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/switch_port_out.sv
// rtl/switch_port_out.sv - egress port: DA filter, admission control, packet FIFO and drop counter
module switch_port_out
    import switch_pkg::*;
#(
    parameter int W_WIDTH    = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_PKT    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [W_WIDTH-1:0] data_in,
    input  logic               sw_enable_in,
    input  logic [W_WIDTH-1:0] port_addr,
    input  logic               read_out,
    output logic [W_WIDTH-1:0] port_out,
    output logic               port_ready,
    output logic               idle,
    output logic [7:0]         drop_cnt,
    output logic               err_long
);

    localparam int PW = ptr_width(FIFO_DEPTH);
    localparam int LW = $clog2(MAX_PKT + 2);

    state_t          r_state;
    logic            r_prev_en;
    logic [LW-1:0]   r_len;
    logic [7:0]      r_drop_cnt;
    logic            r_err_long;
    logic            w_sop;
    logic            w_match;
    logic            w_room;
    logic            w_push;
    logic            w_full;
    logic            w_empty;
    logic [PW:0]     w_count;

    assign w_sop   = sw_enable_in && !r_prev_en;
    assign w_match = (data_in == port_addr) || (data_in == W_WIDTH'(BROADCAST_ADDR));
    // A whole maximum-length packet must fit, so admission never overflows.
    assign w_room  = (w_count <= (PW+1)'(FIFO_DEPTH - MAX_PKT));
    assign w_push  = ((r_state == IDLE) && w_sop && w_match && w_room) ||
                     ((r_state == ACCEPT) && sw_enable_in && !w_full && (r_len < LW'(MAX_PKT)));

    assign port_ready = !w_empty;
    assign idle       = (r_state == IDLE) && w_empty;
    assign drop_cnt   = r_drop_cnt;
    assign err_long   = r_err_long;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_prev_en  <= 1'b1;
            r_len      <= '0;
            r_drop_cnt <= '0;
            r_err_long <= 1'b0;
        end else begin
            r_prev_en  <= sw_enable_in;
            r_err_long <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_sop) begin
                        if (w_match && w_room) begin
                            r_state <= ACCEPT;
                            r_len   <= LW'(1);
                        end else begin
                            r_state <= DISCARD;
                            if (w_match && (r_drop_cnt != 8'hFF)) begin
                                r_drop_cnt <= r_drop_cnt + 8'd1;
                            end
                        end
                    end
                end
                ACCEPT: begin
                    if (!sw_enable_in) begin
                        r_state <= IDLE;
                    end else if (r_len <= LW'(MAX_PKT)) begin
                        // Length stops one past the limit so the error fires only once.
                        r_len <= r_len + LW'(1);
                        if (r_len == LW'(MAX_PKT)) begin
                            r_err_long <= 1'b1;
                        end
                    end
                end
                DISCARD: begin
                    if (!sw_enable_in) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    sync_fifo #(
        .W_WIDTH    (W_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (data_in),
        .i_pop   (read_out),
        .o_rdata (port_out),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

endmodule

// File: tb/tb_switch_port_out.sv
// tb/tb_switch_port_out.sv - directed bench with a packet-level queue model checked every cycle
module tb_switch_port_out;

    localparam int W = 8;
    localparam int D = 16;
    localparam int M = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] data_in = '0;
    logic         sw_enable_in = 1'b0;
    logic [W-1:0] port_addr = 8'h05;
    logic         read_out = 1'b0;
    logic [W-1:0] port_out;
    logic         port_ready;
    logic         idle;
    logic [7:0]   drop_cnt;
    logic         err_long;

    always #5 clk = ~clk;

    switch_port_out #(.W_WIDTH(W), .FIFO_DEPTH(D), .MAX_PKT(M)) dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .sw_enable_in (sw_enable_in),
        .port_addr    (port_addr),
        .read_out     (read_out),
        .port_out     (port_out),
        .port_ready   (port_ready),
        .idle         (idle),
        .drop_cnt     (drop_cnt),
        .err_long     (err_long)
    );

    int        n_tests = 0;
    int        n_fail = 0;
    int        err_seen = 0;
    bit        chk_en = 1'b0;

    logic [7:0] m_q [$];
    bit         m_prev = 1'b1;
    int         m_mode = 0;
    int         m_len = 0;
    int         m_drop = 0;
    logic [7:0] m_out = '0;
    bit         m_err = 1'b0;
    logic [7:0] pkt [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // mode 0 = waiting for a packet, 1 = storing it, 2 = ignoring it
    task automatic model_step();
        bit do_pop;
        bit room;
        if (rst) begin
            m_q.delete();
            m_prev = 1'b1;
            m_mode = 0;
            m_len  = 0;
            m_drop = 0;
            m_out  = '0;
            m_err  = 1'b0;
        end else begin
            do_pop = read_out && (m_q.size() > 0);
            room   = (m_q.size() + M) <= D;
            m_err  = 1'b0;
            if (sw_enable_in && !m_prev && m_mode == 0) begin
                if (data_in == port_addr || data_in == 8'hFF) begin
                    if (room) begin
                        m_mode = 1;
                        m_len  = 1;
                        m_q.push_back(data_in);
                    end else begin
                        m_mode = 2;
                        if (m_drop < 255) m_drop++;
                    end
                end else begin
                    m_mode = 2;
                end
            end else if (sw_enable_in && m_mode == 1) begin
                if (m_len < M) m_q.push_back(data_in);
                if (m_len == M) m_err = 1'b1;
                m_len++;
            end else if (!sw_enable_in) begin
                m_mode = 0;
            end
            if (do_pop) m_out = m_q.pop_front();
            m_prev = sw_enable_in;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("port_out", port_out, m_out);
            check("port_ready", port_ready, m_q.size() != 0);
            check("idle", idle, (m_mode == 0) && (m_q.size() == 0));
            check("drop_cnt", drop_cnt, m_drop);
            check("err_long", err_long, m_err);
            if (err_long) err_seen++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int n);
        for (int i = 0; i < n; i++) begin
            sw_enable_in = 1'b1;
            data_in      = pkt[i];
            tick();
        end
        sw_enable_in = 1'b0;
        data_in      = '0;
        tick();
    endtask

    task automatic drain(input int n);
        read_out = 1'b1;
        repeat (n) tick();
        read_out = 1'b0;
        tick();
    endtask

    initial begin
        tick();
        chk_en = 1'b1;
        tick();
        check("rst port_out", port_out, 8'h00);
        check("rst port_ready", port_ready, 1'b0);
        check("rst idle", idle, 1'b1);
        check("rst drop_cnt", drop_cnt, 8'd0);
        check("rst err_long", err_long, 1'b0);
        rst = 1'b0;
        tick();

        pkt[0] = 8'h05; pkt[1] = 8'h0A; pkt[2] = 8'h11; pkt[3] = 8'h22;
        for (int i = 0; i < 5; i++) begin
            sw_enable_in = (i < 4);
            data_in      = (i < 4) ? pkt[i] : 8'h00;
            read_out     = (i >= 1);
            tick();
            if (i >= 1) check("t1 port_out", port_out, pkt[i-1]);
        end
        read_out = 1'b0;
        check("t1 port_out last", port_out, 8'h22);
        check("t1 ready low", port_ready, 1'b0);
        tick();

        pkt[0] = 8'h07; pkt[1] = 8'h0A; pkt[2] = 8'h33;
        send(3);
        check("t2 miss empty", port_ready, 1'b0);
        check("t2 miss drop", drop_cnt, 8'd0);
        pkt[0] = 8'hFF; pkt[1] = 8'h0A; pkt[2] = 8'h44;
        send(3);
        check("t2 bcast count", dut.w_count, 5'd3);
        drain(3);
        check("t2 bcast last", port_out, 8'h44);

        for (int i = 0; i < 8; i++) pkt[i] = (i == 0) ? 8'h05 : 8'(8'h80 + i);
        send(8);
        send(8);
        send(8);
        check("t3 drop_cnt", drop_cnt, 8'd1);
        check("t3 count", dut.w_count, 5'd16);
        drain(16);
        check("t3 last", port_out, 8'h87);

        err_seen = 0;
        for (int i = 0; i < 10; i++) pkt[i] = (i == 0) ? 8'h05 : 8'(8'h40 + i);
        send(10);
        check("t4 count", dut.w_count, 5'd8);
        check("t4 err pulses", err_seen, 1);
        drain(8);
        check("t4 last", port_out, 8'h47);

        pkt[0] = 8'h05; pkt[1] = 8'h01; pkt[2] = 8'h02; pkt[3] = 8'h03;
        for (int i = 0; i < 4; i++) begin
            sw_enable_in = 1'b1;
            data_in      = pkt[i];
            if (i == 1) port_addr = 8'h09;
            tick();
        end
        sw_enable_in = 1'b0;
        tick();
        check("t5 count", dut.w_count, 5'd4);
        drain(4);
        check("t5 last", port_out, 8'h03);
        port_addr = 8'h05;

        pkt[0] = 8'h05; pkt[1] = 8'h61; pkt[2] = 8'h62;
        pkt[3] = 8'h63; pkt[4] = 8'h64; pkt[5] = 8'h65;
        for (int i = 0; i < 6; i++) begin
            sw_enable_in = 1'b1;
            data_in      = pkt[i];
            rst          = (i == 2);
            read_out     = (i == 2);
            tick();
            if (i == 2) begin
                check("t6 rst port_out", port_out, 8'h00);
                check("t6 rst ready", port_ready, 1'b0);
                check("t6 rst idle", idle, 1'b1);
                check("t6 rst drop", drop_cnt, 8'd0);
            end
        end
        rst = 1'b0;
        read_out = 1'b0;
        check("t6 tail ignored", dut.w_count, 5'd0);
        sw_enable_in = 1'b0;
        tick();
        pkt[0] = 8'h05; pkt[1] = 8'hAA; pkt[2] = 8'hBB;
        send(3);
        check("t6 next count", dut.w_count, 5'd3);
        drain(3);
        check("t6 next last", port_out, 8'hBB);

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
